// File: rtl/draw_srect_if.sv
// Command/RAM-write bundle for the superpixel rectangle drawer.
// The drawer sits on the slave side; the command source and the RAM sit on the master side.
interface draw_srect_if #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8
);
    logic [SPIXEL_X_WIDTH-1:0] x0;
    logic [SPIXEL_Y_WIDTH-1:0] y0;
    logic [SPIXEL_X_WIDTH-1:0] w;
    logic [SPIXEL_Y_WIDTH-1:0] h;
    logic                      mode;
    logic [COLOR_ID_WIDTH-1:0] idata;
    logic                      idata_vld;
    logic                      irdy;
    logic                      iram_busy;
    logic                      odone;
    logic [VGA_ADDR_WIDTH-1:0] oaddr;
    logic [COLOR_ID_WIDTH-1:0] odata;
    logic                      owren;

    modport master (
        output x0, y0, w, h, mode, idata, idata_vld, iram_busy,
        input  irdy, odone, oaddr, odata, owren
    );

    modport slave (
        input  x0, y0, w, h, mode, idata, idata_vld, iram_busy,
        output irdy, odone, oaddr, odata, owren
    );
endinterface

// File: rtl/draw_srect.sv
// Draws a clipped filled or outlined rectangle of superpixels into a
// pixel-addressed frame buffer, one pixel write per cycle in raster order.
module draw_srect #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int SPIXEL_X_CNT   = 64,
    parameter int SPIXEL_Y_CNT   = 48,
    parameter int SPIXEL_SIZE    = 10,
    parameter int PIXEL_X_WIDTH  = 10,
    parameter int PIXEL_Y_WIDTH  = 9,
    parameter int SCREEN_W       = 640,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    draw_srect_if.slave  bus
);
    localparam int SXW  = SPIXEL_X_WIDTH;
    localparam int SYW  = SPIXEL_Y_WIDTH;
    localparam int PXW  = PIXEL_X_WIDTH;
    localparam int PYW  = PIXEL_Y_WIDTH;
    localparam int AW   = VGA_ADDR_WIDTH;
    localparam int CW   = COLOR_ID_WIDTH;
    localparam int SUBW = (SPIXEL_SIZE > 1) ? $clog2(SPIXEL_SIZE) : 1;

    localparam logic [SXW:0]    XCNT    = (SXW+1)'(SPIXEL_X_CNT);
    localparam logic [SYW:0]    YCNT    = (SYW+1)'(SPIXEL_Y_CNT);
    localparam logic [SUBW-1:0] SUB_MAX = SUBW'(SPIXEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SXW-1:0]  r_x0;
    logic [SYW-1:0]  r_y0;
    logic [SXW-1:0]  r_w;
    logic [SYW-1:0]  r_h;
    logic            r_mode;
    logic [CW-1:0]   r_color;
    logic [SXW-1:0]  r_xe1;
    logic [SYW-1:0]  r_ye1;
    logic [PXW-1:0]  r_xstart;
    logic [PXW-1:0]  r_xlast;
    logic [PYW-1:0]  r_ylast;
    logic [PXW-1:0]  r_px;
    logic [PYW-1:0]  r_py;
    logic [SXW-1:0]  r_sx;
    logic [SYW-1:0]  r_sy;
    logic [SUBW-1:0] r_subx;
    logic [SUBW-1:0] r_suby;

    logic [SXW:0]    w_xsum;
    logic [SYW:0]    w_ysum;
    logic [SXW:0]    w_xend;
    logic [SYW:0]    w_yend;
    logic            w_empty;
    logic [PXW-1:0]  w_xstart;
    logic [PYW-1:0]  w_ystart;
    logic [PXW-1:0]  w_xlast;
    logic [PYW-1:0]  w_ylast;
    logic            w_on_edge;
    logic            w_adv;
    logic            w_xwrap;
    logic            w_last;
    logic            w_cap;
    logic            w_load;
    logic            w_irdy;
    logic            w_odone;
    logic            w_owren;
    logic [AW-1:0]   w_addr;

    // Clip in one extra bit so x0+w cannot wrap before the compare.
    assign w_xsum = {1'b0, r_x0} + {1'b0, r_w};
    assign w_ysum = {1'b0, r_y0} + {1'b0, r_h};
    assign w_xend = (w_xsum > XCNT) ? XCNT : w_xsum;
    assign w_yend = (w_ysum > YCNT) ? YCNT : w_ysum;

    assign w_empty = (r_w == '0) || (r_h == '0) ||
                     ({1'b0, r_x0} >= XCNT) ||
                     ({1'b0, r_y0} >= YCNT);

    assign w_xstart = PXW'(r_x0) * PXW'(SPIXEL_SIZE);
    assign w_ystart = PYW'(r_y0) * PYW'(SPIXEL_SIZE);
    assign w_xlast  = PXW'(w_xend) * PXW'(SPIXEL_SIZE) - PXW'(1);
    assign w_ylast  = PYW'(w_yend) * PYW'(SPIXEL_SIZE) - PYW'(1);

    // Outline pixels: superpixel on the first/last clipped column or row.
    assign w_on_edge = !r_mode ||
                       (r_sx == r_x0) || (r_sx == r_xe1) ||
                       (r_sy == r_y0) || (r_sy == r_ye1);

    assign w_adv   = (r_state == DRAW) && !bus.iram_busy;
    assign w_xwrap = (r_px == r_xlast);
    assign w_last  = w_xwrap && (r_py == r_ylast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_irdy  = 1'b0;
        w_odone = 1'b0;
        w_owren = 1'b0;
        w_cap   = 1'b0;
        w_load  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_irdy = 1'b1;
                if (bus.idata_vld) begin
                    w_cap  = 1'b1;
                    w_next = SETUP;
                end
            end
            SETUP: begin
                if (w_empty) begin
                    w_next = DONE;
                end else begin
                    w_load = 1'b1;
                    w_next = DRAW;
                end
            end
            DRAW: begin
                w_owren = w_on_edge;
                if (w_adv && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_odone = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_mode  <= 1'b0;
            r_color <= '0;
        end else if (w_cap) begin
            r_x0    <= bus.x0;
            r_y0    <= bus.y0;
            r_w     <= bus.w;
            r_h     <= bus.h;
            r_mode  <= bus.mode;
            r_color <= bus.idata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xe1    <= '0;
            r_ye1    <= '0;
            r_xstart <= '0;
            r_xlast  <= '0;
            r_ylast  <= '0;
        end else if (w_load) begin
            r_xe1    <= SXW'(w_xend - (SXW+1)'(1));
            r_ye1    <= SYW'(w_yend - (SYW+1)'(1));
            r_xstart <= w_xstart;
            r_xlast  <= w_xlast;
            r_ylast  <= w_ylast;
        end
    end

    // Superpixel indices ride along with the pixel counters to avoid a divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_px   <= '0;
            r_py   <= '0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_subx <= '0;
            r_suby <= '0;
        end else if (w_load) begin
            r_px   <= w_xstart;
            r_py   <= w_ystart;
            r_sx   <= r_x0;
            r_sy   <= r_y0;
            r_subx <= '0;
            r_suby <= '0;
        end else if (w_adv && !w_last) begin
            if (w_xwrap) begin
                r_px   <= r_xstart;
                r_sx   <= r_x0;
                r_subx <= '0;
                r_py   <= r_py + PYW'(1);
                if (r_suby == SUB_MAX) begin
                    r_suby <= '0;
                    r_sy   <= r_sy + SYW'(1);
                end else begin
                    r_suby <= r_suby + SUBW'(1);
                end
            end else begin
                r_px <= r_px + PXW'(1);
                if (r_subx == SUB_MAX) begin
                    r_subx <= '0;
                    r_sx   <= r_sx + SXW'(1);
                end else begin
                    r_subx <= r_subx + SUBW'(1);
                end
            end
        end
    end

    assign w_addr = AW'(r_py) * AW'(SCREEN_W) + AW'(r_px);

    assign bus.irdy  = w_irdy;
    assign bus.odone = w_odone;
    assign bus.owren = w_owren;
    assign bus.oaddr = w_addr;
    assign bus.odata = r_color;
endmodule

// File: tb/tb_draw_srect.sv
// Directed bench for draw_srect: fill, outline, clip, degenerate,
// back-pressure, command-hold and mid-draw reset scenarios.
module tb_draw_srect;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    draw_srect_if bus ();

    draw_srect dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    int          r_nwr;
    int          r_first;
    int          r_last;
    int          r_cyc;
    int          r_first_cyc;
    int          r_center;
    int          r_hold_err;
    int          r_data_err;
    int          r_timeout;
    int          r_done_after;
    int          r_irdy_after;
    logic [31:0] r_hash;

    int          m_cnt;
    int          m_scan;
    logic [31:0] m_hash;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: enumerate the clipped rectangle pixel by pixel.
    task automatic model(input int x0, input int y0, input int w,
                         input int h, input bit md);
        int xe;
        int ye;
        int sx;
        int sy;
        bit edge_px;
        m_cnt  = 0;
        m_scan = 0;
        m_hash = '0;
        xe = (x0 + w > 64) ? 64 : x0 + w;
        ye = (y0 + h > 48) ? 48 : y0 + h;
        if (w == 0 || h == 0 || x0 >= 64 || y0 >= 48) return;
        for (int py = y0 * 10; py < ye * 10; py++) begin
            for (int px = x0 * 10; px < xe * 10; px++) begin
                sx = px / 10;
                sy = py / 10;
                m_scan++;
                edge_px = !md || sx == x0 || sx == xe - 1 ||
                          sy == y0 || sy == ye - 1;
                if (edge_px) begin
                    m_cnt++;
                    m_hash = m_hash * 32'd31 + 32'(py * 640 + px);
                end
            end
        end
    endtask

    task automatic run(input int x0, input int y0, input int w,
                       input int h, input bit md, input logic [7:0] col,
                       input int busy_pct, input bit hold_vld);
        int          waited;
        int          cyc;
        bit          busy;
        bit          held_v;
        logic [18:0] held;
        int          ax;
        int          ay;
        r_nwr        = 0;
        r_first      = -1;
        r_last       = -1;
        r_first_cyc  = -1;
        r_center     = 0;
        r_hold_err   = 0;
        r_data_err   = 0;
        r_hash       = '0;
        r_done_after = -1;
        r_irdy_after = -1;
        held_v       = 1'b0;
        held         = '0;
        waited       = 0;
        @(negedge clk);
        while (!bus.irdy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        bus.x0        = 6'(x0);
        bus.y0        = 6'(y0);
        bus.w         = 6'(w);
        bus.h         = 6'(h);
        bus.mode      = md;
        bus.idata     = col;
        bus.idata_vld = 1'b1;
        @(negedge clk);
        if (hold_vld) begin
            bus.x0    = 6'd40;
            bus.y0    = 6'd30;
            bus.w     = 6'd2;
            bus.h     = 6'd2;
            bus.mode  = ~md;
            bus.idata = ~col;
        end else begin
            bus.idata_vld = 1'b0;
        end
        cyc = 1;
        while (cyc < 20000) begin
            if (bus.odone) break;
            if (bus.owren) begin
                if (r_first_cyc < 0) r_first_cyc = cyc;
                if (bus.odata !== col) r_data_err++;
            end
            if (held_v && (bus.oaddr !== held || !bus.owren)) r_hold_err++;
            busy = (busy_pct > 0) && ($urandom_range(99) < busy_pct);
            bus.iram_busy = busy;
            held_v = busy && bus.owren;
            held   = bus.oaddr;
            if (bus.owren && !busy) begin
                if (r_first < 0) r_first = int'(bus.oaddr);
                r_last = int'(bus.oaddr);
                r_nwr++;
                r_hash = r_hash * 32'd31 + 32'(bus.oaddr);
                ax = int'(bus.oaddr) % 640;
                ay = int'(bus.oaddr) / 640;
                if (ax >= 10 && ax <= 19 && ay >= 10 && ay <= 19) r_center++;
            end
            @(negedge clk);
            cyc++;
        end
        r_cyc     = cyc;
        r_timeout = bus.odone ? 0 : 1;
        bus.idata_vld = 1'b0;
        bus.iram_busy = 1'b0;
        if (!r_timeout) begin
            @(negedge clk);
            r_done_after = int'(bus.odone);
            r_irdy_after = int'(bus.irdy);
        end
    endtask

    initial begin
        int seen_wr;
        int seen_done;
        bus.x0        = '0;
        bus.y0        = '0;
        bus.w         = '0;
        bus.h         = '0;
        bus.mode      = 1'b0;
        bus.idata     = '0;
        bus.idata_vld = 1'b0;
        bus.iram_busy = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_owren", bus.owren, 0);
        chk("rst_odone", bus.odone, 0);
        chk("rst_oaddr", bus.oaddr, 0);
        chk("rst_odata", bus.odata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_irdy", bus.irdy, 1);

        run(1, 2, 1, 1, 1'b0, 8'h2A, 0, 1'b0);
        model(1, 2, 1, 1, 1'b0);
        chk("fill_timeout", r_timeout, 0);
        chk("fill_writes", r_nwr, 100);
        chk("fill_first", r_first, 12810);
        chk("fill_last", r_last, 18579);
        chk("fill_data", r_data_err, 0);
        chk("fill_lat", r_first_cyc, 2);
        chk("fill_cycles", r_cyc, 102);
        chk("fill_hash", r_hash, m_hash);
        chk("fill_pulse", r_done_after, 0);
        chk("fill_irdy", r_irdy_after, 1);

        run(0, 0, 3, 3, 1'b0, 8'h11, 0, 1'b0);
        model(0, 0, 3, 3, 1'b0);
        chk("box0_writes", r_nwr, 900);
        chk("box0_center", r_center, 100);
        chk("box0_cycles", r_cyc, 902);
        chk("box0_hash", r_hash, m_hash);

        run(0, 0, 3, 3, 1'b1, 8'h22, 0, 1'b0);
        model(0, 0, 3, 3, 1'b1);
        chk("box1_writes", r_nwr, 800);
        chk("box1_center", r_center, 0);
        chk("box1_cycles", r_cyc, 902);
        chk("box1_hash", r_hash, m_hash);
        chk("box1_data", r_data_err, 0);

        run(62, 46, 5, 5, 1'b0, 8'h7E, 0, 1'b0);
        model(62, 46, 5, 5, 1'b0);
        chk("clip_writes", r_nwr, 400);
        chk("clip_first", r_first, 295020);
        chk("clip_last", r_last, 307199);
        chk("clip_cycles", r_cyc, 402);
        chk("clip_hash", r_hash, m_hash);

        run(3, 3, 0, 4, 1'b0, 8'h01, 0, 1'b0);
        chk("w0_writes", r_nwr, 0);
        chk("w0_owren", r_first_cyc, -1);
        chk("w0_done", r_cyc, 2);
        chk("w0_irdy", r_irdy_after, 1);

        run(3, 3, 4, 0, 1'b0, 8'h02, 0, 1'b0);
        chk("h0_writes", r_nwr, 0);
        chk("h0_done", r_cyc, 2);

        run(3, 50, 4, 4, 1'b0, 8'h03, 0, 1'b0);
        chk("yoff_writes", r_nwr, 0);
        chk("yoff_done", r_cyc, 2);

        run(0, 0, 3, 3, 1'b1, 8'h55, 50, 1'b0);
        model(0, 0, 3, 3, 1'b1);
        chk("bp_timeout", r_timeout, 0);
        chk("bp_writes", r_nwr, 800);
        chk("bp_hash", r_hash, m_hash);
        chk("bp_hold", r_hold_err, 0);
        chk("bp_data", r_data_err, 0);
        chk("bp_center", r_center, 0);

        run(1, 2, 1, 1, 1'b0, 8'hC3, 0, 1'b1);
        model(1, 2, 1, 1, 1'b0);
        chk("vld_writes", r_nwr, 100);
        chk("vld_hash", r_hash, m_hash);
        chk("vld_data", r_data_err, 0);
        chk("vld_cycles", r_cyc, 102);

        @(negedge clk);
        bus.x0        = 6'd0;
        bus.y0        = 6'd0;
        bus.w         = 6'd3;
        bus.h         = 6'd3;
        bus.mode      = 1'b0;
        bus.idata     = 8'h99;
        bus.idata_vld = 1'b1;
        @(negedge clk);
        bus.idata_vld = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort_drawing", bus.owren, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_owren", bus.owren, 0);
        chk("abort_odone", bus.odone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_irdy", bus.irdy, 1);
        seen_wr   = 0;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.owren) seen_wr++;
            if (bus.odone) seen_done++;
        end
        chk("abort_nowr", seen_wr, 0);
        chk("abort_nodone", seen_done, 0);

        run(5, 5, 2, 1, 1'b1, 8'h09, 0, 1'b0);
        chk("post_writes", r_nwr, 200);
        chk("post_first", r_first, 32050);
        chk("post_last", r_last, 37829);
        chk("post_cycles", r_cyc, 202);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
